// File: rtl/mux_scan_sequencer.sv
// Scans a 4-to-1 mux through channels 0..3 and dwells on each channel.
// The sampled Y values are assembled into a 4-bit word, and a done pulse marks each completed sweep.
module mux_scan_sequencer #(
    parameter int unsigned DWELL = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       continuous,
    input  logic       Y,
    output logic       A,
    output logic       B,
    output logic       busy,
    output logic       done,
    output logic [3:0] data_out
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       sel;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       shadow;
    logic             dwell_end;
    logic             sweep_end;

    always_comb begin
        dwell_end = (state == SCAN) && (cnt == CNT_LAST);
        sweep_end = dwell_end && (sel == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (sweep_end && !continuous) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The channel 3 sample bypasses the shadow register and goes straight into data_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel      <= '0;
            cnt      <= '0;
            shadow   <= '0;
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    sel <= '0;
                    cnt <= '0;
                end
            end else if (dwell_end) begin
                cnt <= '0;
                sel <= sel + 2'd1;
                case (sel)
                    2'd0: shadow[0] <= Y;
                    2'd1: shadow[1] <= Y;
                    2'd2: shadow[2] <= Y;
                    default: begin
                        data_out <= {Y, shadow};
                        done     <= 1'b1;
                    end
                endcase
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        A    = sel[1];
        B    = sel[0];
        busy = (state == SCAN);
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench: stimulus queues the expected word and its completion cycle, and a monitor checks each done pulse.
// One DUT uses DWELL=2 and a second uses DWELL=1. Each DUT is driven by its own behavioural 4-to-1 mux model.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, continuous, start2;
    logic [3:0] i_vec, i_vec2;
    logic       y, a, b, busy, done;
    logic       y2, a2, b2, busy2, done2;
    logic [3:0] data_out, data_out2;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [3:0] data;
        int         at_cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign y  = i_vec[{a, b}];
    assign y2 = i_vec2[{a2, b2}];

    mux_scan_sequencer #(.DWELL(2), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous), .Y(y),
        .A(a), .B(b), .busy(busy), .done(done), .data_out(data_out)
    );

    mux_scan_sequencer #(.DWELL(1), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .continuous(1'b0), .Y(y2),
        .A(a2), .B(b2), .busy(busy2), .done(done2), .data_out(data_out2)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q1.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("data_out", int'(data_out), int'(e.data));
                chk("done_cycle", cyc, e.at_cyc);
            end
        end
        if (done2) begin
            if (q2.size() == 0) begin
                chk("unexpected_done_d1", 1, 0);
            end else begin
                e = q2.pop_front();
                chk("data_out_d1", int'(data_out2), int'(e.data));
                chk("done_cycle_d1", cyc, e.at_cyc);
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; continuous = 1'b0; start2 = 1'b0;
        i_vec = '0; i_vec2 = '0;

        // Test 1: reset, then remain idle.
        step(); step();
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("idle_ab", int'({a, b}), 0);
            chk("idle_busy", int'(busy), 0);
            chk("idle_data", int'(data_out), 0);
        end

        // Test 2: single sweep with I = 1010.
        step();
        i_vec = 4'b1010; n = cyc; start = 1'b1;
        q1.push_back('{4'b1010, n + 1 + 8});
        step(); start = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("sweep_ab", int'({a, b}), j / 2);
            chk("sweep_busy", int'(busy), 1);
        end
        @(negedge clk);
        chk("t2_done", int'(done), 1);
        chk("t2_busy_after", int'(busy), 0);
        @(negedge clk);
        chk("t2_done_pulse", int'(done), 0);

        // Test 3: continuous sweeps with I = 0110 and then I = 1001.
        step();
        i_vec = 4'b0110; continuous = 1'b1; n = cyc; start = 1'b1;
        q1.push_back('{4'b0110, n + 1 + 8});
        q1.push_back('{4'b1001, n + 1 + 16});
        step(); start = 1'b0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            chk("cont_busy", int'(busy), 1);
            if (j == 8) i_vec = 4'b1001;
            if (j == 12) continuous = 1'b0;
        end
        @(negedge clk);
        chk("t3_busy_end", int'(busy), 0);

        // Test 4: start held through the whole sweep.
        step();
        i_vec = 4'b0011; n = cyc; start = 1'b1;
        q1.push_back('{4'b0011, n + 1 + 8});
        repeat (8) step();
        @(negedge clk);
        chk("t4_busy_held", int'(busy), 1);
        step();
        start = 1'b0;
        @(negedge clk);
        chk("t4_idle", int'(busy), 0);
        step();
        @(negedge clk);
        chk("t4_no_restart", int'(busy), 0);

        // Test 5: set data_out to 1111, then abort a sweep with reset.
        step();
        i_vec = 4'b1111; n = cyc; start = 1'b1;
        q1.push_back('{4'b1111, n + 1 + 8});
        step(); start = 1'b0;
        repeat (9) step();
        chk("t5_prior", int'(data_out), 15);
        i_vec = 4'b0101; start = 1'b1;
        step(); start = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        step(); reset = 1'b0;
        @(negedge clk);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_data", int'(data_out), 0);
        chk("t5_rst_ab", int'({a, b}), 0);
        step();
        n = cyc; start = 1'b1;
        q1.push_back('{4'b0101, n + 1 + 8});
        step(); start = 1'b0;
        repeat (9) step();

        // Test 6: continuous cleared after edge k+2, plus a DWELL=1 sweep.
        step();
        i_vec = 4'b1100; continuous = 1'b1; n = cyc; start = 1'b1;
        q1.push_back('{4'b1100, n + 1 + 8});
        i_vec2 = 4'b1101; start2 = 1'b1;
        q2.push_back('{4'b1101, n + 1 + 4});
        step(); start = 1'b0; start2 = 1'b0;
        step(); step();
        continuous = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk("t6_idle", int'(busy), 0);
        chk("t6_d1_idle", int'(busy2), 0);
        step();
        @(negedge clk);
        chk("t6_stay_idle", int'(busy), 0);

        repeat (20) step();
        chk("missing_done", q1.size(), 0);
        chk("missing_done_d1", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
